// File: rtl/boot_pkg.sv
// Shared types and default sizing for the boot harness.
package boot_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int IMEM_DEPTH_DEF = 256;
    localparam int TIMEOUT_DEF    = 1000;

    // Harness sequencing: idle, stream image, core running, result held
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/boot_harness_run_monitor.sv
// Watches core writeback for the signature register, counts run cycles
// and flags the timeout. Reports a single end-of-run event to the FSM.
module run_monitor
    import boot_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SIG_REG = 10,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             active,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             run_end,
    output logic             run_pass,
    output logic             run_timeout,
    output logic [XLEN-1:0]  run_code,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [4:0]       SIG_RD   = 5'(SIG_REG);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] cycles_d;
    logic             sig_hit;
    logic             tmo_hit;

    // Classify this cycle: signature write wins over an expiring timer
    always_comb begin
        sig_hit     = active && wb_en && (wb_rd == SIG_RD);
        tmo_hit     = active && !sig_hit && (cycles_q == TMO_LAST);
        run_end     = sig_hit || tmo_hit;
        run_pass    = sig_hit && (wb_data == '0);
        run_timeout = tmo_hit;
        run_code    = (sig_hit && (wb_data != '0)) ? wb_data : '0;
    end

    // Next count: cleared on a new load, frozen on the ending cycle, saturating
    always_comb begin
        cycles_d = cycles_q;
        if (clear) begin
            cycles_d = '0;
        end else if (active && !run_end && (cycles_q != '1)) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;

endmodule

// File: rtl/boot_harness.sv
// Boot harness: streams a program image into instruction memory, releases
// the core from reset at the boot PC, then records the run result.
module boot_harness
    import boot_pkg::*;
#(
    parameter int          XLEN       = XLEN_DEF,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int unsigned BOOT_PC    = 0,
    parameter int          SIG_REG    = 10,
    parameter int          TIMEOUT    = TIMEOUT_DEF,
    parameter int          CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          ld_valid,
    input  logic [XLEN-1:0]               ld_data,
    input  logic                          ld_last,
    output logic                          ld_ready,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [XLEN-1:0]               imem_wdata,
    output logic                          cpu_rst_n,
    output logic [XLEN-1:0]               pc_init,
    input  logic                          wb_en,
    input  logic [4:0]                    wb_rd,
    input  logic [XLEN-1:0]               wb_data,
    output logic                          done,
    output logic                          pass,
    output logic [XLEN-1:0]               fail_code,
    output logic                          timeout,
    output logic                          overflow,
    output logic [CNT_W-1:0]              cycles
);

    localparam int            AW        = $clog2(IMEM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              ld_ready_q, ld_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [AW-1:0]     imem_addr_q, imem_addr_d;
    logic [XLEN-1:0]   imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [XLEN-1:0]   fail_code_q, fail_code_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;

    logic              mon_clear;
    logic              mon_active;
    logic              mon_end;
    logic              mon_pass;
    logic              mon_timeout;
    logic [XLEN-1:0]   mon_code;

    // The core only counts as running once its reset has actually been released
    assign mon_active = (state_q == ST_RUN) && cpu_rst_n_q;

    run_monitor #(
        .XLEN    (XLEN),
        .SIG_REG (SIG_REG),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_run_monitor (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (mon_clear),
        .active      (mon_active),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .run_end     (mon_end),
        .run_pass    (mon_pass),
        .run_timeout (mon_timeout),
        .run_code    (mon_code),
        .cycles      (cycles)
    );

    // Next-state and registered-output logic for the load/run sequence
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ld_ready_d   = ld_ready_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_n_d  = 1'b0;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_code_d  = fail_code_q;
        timeout_d    = timeout_q;
        overflow_d   = overflow_q;
        mon_clear    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    ld_ready_d  = 1'b1;
                    addr_d      = '0;
                    imem_addr_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_code_d = '0;
                    timeout_d   = 1'b0;
                    overflow_d  = 1'b0;
                    mon_clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = addr_q;
                    imem_wdata_d = ld_data;
                    addr_d       = addr_q + AW'(1);
                    if (ld_last) begin
                        // Core release waits one more cycle so the last write lands first
                        state_d    = ST_RUN;
                        ld_ready_d = 1'b0;
                    end else if (addr_q == LAST_ADDR) begin
                        // Image does not fit: keep the word, refuse the rest, never boot
                        state_d    = ST_DONE;
                        ld_ready_d = 1'b0;
                        done_d     = 1'b1;
                        pass_d     = 1'b0;
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cpu_rst_n_d = 1'b1;
                if (mon_end) begin
                    state_d     = ST_DONE;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = mon_pass;
                    fail_code_d = mon_code;
                    timeout_d   = mon_timeout;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            ld_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= '0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            ld_ready_q   <= ld_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_code_q  <= fail_code_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign pc_init    = XLEN'(BOOT_PC);
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_code  = fail_code_q;
    assign timeout    = timeout_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_boot_harness.sv
// Bench for boot_harness: three instances (default, short timeout, tiny
// memory) share one stimulus bus; a small RV32I-subset core model runs
// the directed programs, and random writeback runs are checked against
// a cycle-count reference model.
module tb_boot_harness;

    localparam int SIG = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    int          sel;
    logic        ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st0, st1, st2;

    logic        d_ld_ready[3], d_imem_we[3], d_cpu_rst_n[3], d_done[3];
    logic        d_pass[3], d_timeout[3], d_overflow[3];
    logic [31:0] d_wdata[3], d_pc[3], d_code[3], d_cycles[3];
    logic [7:0]  d_addr[2];
    logic [1:0]  o_addr;

    logic        s_ld_ready, s_imem_we, s_cpu_rst_n, s_done, s_pass, s_timeout, s_overflow;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata, s_pc, s_code, s_cycles;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] img[16];
    int          loaded;
    bit          use_core;
    logic        r_wb_en;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    always #5 clk = ~clk;

    assign st0 = start && (sel == 0);
    assign st1 = start && (sel == 1);
    assign st2 = start && (sel == 2);

    boot_harness #(.IMEM_DEPTH(256), .TIMEOUT(1000)) u_main (
        .clk(clk), .rst_n(rst_n), .start(st0), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(d_ld_ready[0]), .imem_we(d_imem_we[0]),
        .imem_addr(d_addr[0]), .imem_wdata(d_wdata[0]), .cpu_rst_n(d_cpu_rst_n[0]),
        .pc_init(d_pc[0]), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(d_done[0]), .pass(d_pass[0]), .fail_code(d_code[0]), .timeout(d_timeout[0]),
        .overflow(d_overflow[0]), .cycles(d_cycles[0]));

    boot_harness #(.IMEM_DEPTH(256), .TIMEOUT(50)) u_tmo (
        .clk(clk), .rst_n(rst_n), .start(st1), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(d_ld_ready[1]), .imem_we(d_imem_we[1]),
        .imem_addr(d_addr[1]), .imem_wdata(d_wdata[1]), .cpu_rst_n(d_cpu_rst_n[1]),
        .pc_init(d_pc[1]), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(d_done[1]), .pass(d_pass[1]), .fail_code(d_code[1]), .timeout(d_timeout[1]),
        .overflow(d_overflow[1]), .cycles(d_cycles[1]));

    boot_harness #(.IMEM_DEPTH(4), .TIMEOUT(1000)) u_ovf (
        .clk(clk), .rst_n(rst_n), .start(st2), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(d_ld_ready[2]), .imem_we(d_imem_we[2]),
        .imem_addr(o_addr), .imem_wdata(d_wdata[2]), .cpu_rst_n(d_cpu_rst_n[2]),
        .pc_init(d_pc[2]), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(d_done[2]), .pass(d_pass[2]), .fail_code(d_code[2]), .timeout(d_timeout[2]),
        .overflow(d_overflow[2]), .cycles(d_cycles[2]));

    // Observe the instance currently under test
    always_comb begin
        s_ld_ready  = d_ld_ready[sel];
        s_imem_we   = d_imem_we[sel];
        s_cpu_rst_n = d_cpu_rst_n[sel];
        s_done      = d_done[sel];
        s_pass      = d_pass[sel];
        s_timeout   = d_timeout[sel];
        s_overflow  = d_overflow[sel];
        s_wdata     = d_wdata[sel];
        s_pc        = d_pc[sel];
        s_code      = d_code[sel];
        s_cycles    = d_cycles[sel];
        s_addr      = (sel == 2) ? {6'b0, o_addr} : d_addr[sel];
    end

    // ---------------- core model (environment, single-cycle RV32I subset)
    logic [31:0] tmem[256];
    logic [31:0] core_x[32];
    logic [31:0] core_pc;
    logic [31:0] c_inst, c_rs1, c_rs2, c_data, c_npc;
    logic        c_en;
    logic [4:0]  c_rd;

    always_comb begin
        c_inst = tmem[core_pc[9:2]];
        c_rs1  = core_x[c_inst[19:15]];
        c_rs2  = core_x[c_inst[24:20]];
        c_en   = 1'b0;
        c_rd   = c_inst[11:7];
        c_data = '0;
        c_npc  = core_pc + 32'd4;
        case (c_inst[6:0])
            7'h13: begin c_en = 1'b1; c_data = c_rs1 + {{20{c_inst[31]}}, c_inst[31:20]}; end
            7'h33: begin c_en = 1'b1; c_data = c_rs1 + c_rs2; end
            7'h63: if (c_rs1 == c_rs2)
                       c_npc = core_pc + {{19{c_inst[31]}}, c_inst[31], c_inst[7],
                                          c_inst[30:25], c_inst[11:8], 1'b0};
            7'h6f: begin
                c_en   = 1'b1;
                c_data = core_pc + 32'd4;
                c_npc  = core_pc + {{11{c_inst[31]}}, c_inst[31], c_inst[19:12],
                                    c_inst[20], c_inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (s_imem_we) tmem[s_addr] <= s_wdata;
        if (!s_cpu_rst_n) begin
            core_pc <= s_pc;
            for (int r = 0; r < 32; r++) core_x[r] <= '0;
        end else begin
            if (c_en && c_rd != 5'd0) core_x[c_rd] <= c_data;
            core_pc <= c_npc;
        end
    end

    always_comb begin
        if (use_core) begin
            wb_en = c_en && s_cpu_rst_n; wb_rd = c_rd; wb_data = c_data;
        end else begin
            wb_en = r_wb_en; wb_rd = r_wb_rd; wb_data = r_wb_data;
        end
    end

    // ---------------- helpers
    function automatic logic [31:0] f_addi(input int rd, input int rs1, input int imm);
        logic [11:0] i12;
        i12 = 12'(imm);
        return {i12, 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] f_add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] f_beq(input int rs1, input int rs2, input int imm);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b000, b[4:1], b[11], 7'h63};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prog(input int x4_imm);
        img[0] = f_addi(1, 0, 5);
        img[1] = f_addi(2, 0, 3);
        img[2] = f_addi(3, 0, 0);
        img[3] = f_add(3, 2, 1);
        img[4] = f_addi(4, 0, x4_imm);
        img[5] = f_beq(3, 4, 12);
        img[6] = f_addi(10, 0, 1);
        img[7] = f_addi(0, 0, 0);
        img[8] = f_addi(10, 0, 0);
    endtask

    task automatic check_reset();
        chk("rst_ld_ready", s_ld_ready, 0);   chk("rst_imem_we", s_imem_we, 0);
        chk("rst_imem_addr", s_addr, 0);      chk("rst_imem_wdata", s_wdata, 0);
        chk("rst_cpu_rst_n", s_cpu_rst_n, 0); chk("rst_done", s_done, 0);
        chk("rst_pass", s_pass, 0);           chk("rst_fail_code", s_code, 0);
        chk("rst_timeout", s_timeout, 0);     chk("rst_overflow", s_overflow, 0);
        chk("rst_cycles", s_cycles, 0);       chk("pc_init", s_pc, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ld_ready", s_ld_ready, 1); chk("start_done_clr", s_done, 0);
        chk("start_ovf_clr", s_overflow, 0);  chk("start_tmo_clr", s_timeout, 0);
        chk("start_cycles_clr", s_cycles, 0); chk("start_code_clr", s_code, 0);
    endtask

    // Stream n words with random gaps; limit = words the harness should accept
    task automatic load_image(input int n, input bit with_last, input int depth, input int max_cyc);
        int  i;
        int  limit;
        bit  hs;
        i = 0;
        limit = with_last ? n : depth;
        for (int c = 0; c < max_cyc && !(with_last && i == n); c++) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = img[(i < n) ? i : n - 1];
            ld_last  = with_last && (i == n - 1);
            start    = (i < limit) && ($urandom_range(0, 7) == 0);
            chk("ld_ready", s_ld_ready, (i < limit));
            chk("load_cpu_rst_n", s_cpu_rst_n, 0);
            hs = ld_valid && (i < limit);
            tick();
            if (hs) begin
                chk("wr_we", s_imem_we, 1);
                chk("wr_addr", s_addr, i);
                chk("wr_data", s_wdata, img[i]);
                i++;
            end else begin
                chk("no_wr", s_imem_we, 0);
            end
        end
        start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        loaded = i;
    endtask

    task automatic post_load(input int n);
        chk("load_count", loaded, n);
        chk("last_wr_core_held", s_cpu_rst_n, 0);
        tick();
        chk("core_release", s_cpu_rst_n, 1);
        chk("release_no_wr", s_imem_we, 0);
        chk("release_ld_ready", s_ld_ready, 0);
        chk("release_done", s_done, 0);
    endtask

    task automatic hold_check(input bit ep, input logic [31:0] ec, input bit et, input int ecy);
        use_core = 1'b0;
        for (int h = 0; h < 3; h++) begin
            r_wb_en = 1'b1; r_wb_rd = 5'(SIG); r_wb_data = $urandom;
            tick();
            chk("hold_done", s_done, 1);     chk("hold_pass", s_pass, ep);
            chk("hold_code", s_code, ec);    chk("hold_timeout", s_timeout, et);
            chk("hold_cycles", s_cycles, ecy); chk("hold_cpu_rst_n", s_cpu_rst_n, 0);
        end
        r_wb_en = 1'b0;
    endtask

    task automatic core_run(input int budget, input bit ep, input logic [31:0] ec, input bit et, input int ecy);
        bit got;
        got = 1'b0;
        use_core = 1'b1;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            got = s_done;
        end
        $display("core run sel=%0d done=%0d pass=%0d code=%0h timeout=%0d cycles=%0d",
                 sel, s_done, s_pass, s_code, s_timeout, s_cycles);
        chk("run_done", got, 1);     chk("run_pass", s_pass, ep);
        chk("run_code", s_code, ec); chk("run_timeout", s_timeout, et);
        chk("run_cycles", s_cycles, ecy);
        chk("run_core_frozen", s_cpu_rst_n, 0);
        hold_check(ep, ec, et, ecy);
    endtask

    // Random writeback; force_k places a signature write on that run cycle
    task automatic random_run(input int tmo, input int force_k);
        int          k;
        bit          ended, sig, ep, et;
        logic [31:0] dv, ec;
        k = 0; ended = 1'b0; ep = 1'b0; et = 1'b0; ec = '0;
        use_core = 1'b0;
        while (!ended && k < tmo) begin
            if (k == force_k) begin
                r_wb_en = 1'b1; r_wb_rd = 5'(SIG);
                r_wb_data = ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom;
            end else begin
                r_wb_en   = ($urandom_range(0, 1) != 0);
                r_wb_rd   = 5'($urandom_range(0, 31));
                r_wb_data = ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom;
                if (force_k >= 0 && r_wb_en && r_wb_rd == 5'(SIG)) r_wb_rd = 5'd0;
            end
            start = ($urandom_range(0, 7) == 0);
            sig = r_wb_en && (r_wb_rd == 5'(SIG));
            dv  = r_wb_data;
            tick();
            if (sig) begin
                ended = 1'b1; ep = (dv == 0); ec = (dv == 0) ? 32'd0 : dv; et = 1'b0;
            end else if (k == tmo - 1) begin
                ended = 1'b1; ep = 1'b0; ec = '0; et = 1'b1;
            end else begin
                chk("running_done", s_done, 0);
                chk("running_cycles", s_cycles, k + 1);
                chk("running_cpu_rst_n", s_cpu_rst_n, 1);
                k++;
            end
        end
        start = 1'b0; r_wb_en = 1'b0;
        $display("random run sel=%0d force_k=%0d end_k=%0d pass=%0d code=%0h timeout=%0d cycles=%0d",
                 sel, force_k, k, s_pass, s_code, s_timeout, s_cycles);
        chk("rr_done", s_done, 1);     chk("rr_pass", s_pass, ep);
        chk("rr_code", s_code, ec);    chk("rr_timeout", s_timeout, et);
        chk("rr_cycles", s_cycles, k); chk("rr_overflow", s_overflow, 0);
        chk("rr_cpu_rst_n", s_cpu_rst_n, 0);
        hold_check(ep, ec, et, k);
    endtask

    // ---------------- directed sequence
    initial begin
        rst_n = 1'b0; start = 1'b0; sel = 0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        use_core = 1'b0; r_wb_en = 1'b0; r_wb_rd = '0; r_wb_data = '0;
        tick(); tick();
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check_reset();
        end
        rst_n = 1'b1;
        tick();

        // Passing program on the default instance
        sel = 0; #1;
        set_prog(8);
        do_start();
        load_image(9, 1'b1, 256, 200);
        post_load(9);
        core_run(100, 1'b1, 32'd0, 1'b0, 6);

        // Failing variant, restarted from DONE
        set_prog(9);
        do_start();
        load_image(9, 1'b1, 256, 200);
        post_load(9);
        core_run(100, 1'b0, 32'd1, 1'b0, 6);

        // Infinite loop against TIMEOUT=50
        sel = 1; #1;
        img[0] = f_addi(1, 0, 1);
        img[1] = f_addi(2, 0, 2);
        img[2] = 32'h0000_006f;
        do_start();
        load_image(3, 1'b1, 256, 100);
        post_load(3);
        core_run(200, 1'b0, 32'd0, 1'b1, 49);

        // Overflow on IMEM_DEPTH=4: six words, no last marker
        sel = 2; #1;
        for (int w = 0; w < 6; w++) img[w] = $urandom;
        do_start();
        load_image(6, 1'b0, 4, 40);
        chk("ovf_accepted", loaded, 4);
        chk("ovf_flag", s_overflow, 1); chk("ovf_done", s_done, 1);
        chk("ovf_pass", s_pass, 0);     chk("ovf_ld_ready", s_ld_ready, 0);
        for (int h = 0; h < 4; h++) begin
            tick();
            chk("ovf_core_held", s_cpu_rst_n, 0);
            chk("ovf_hold", s_overflow, 1);
        end

        // Last word exactly at IMEM_DEPTH-1 boots normally
        for (int w = 0; w < 4; w++) img[w] = $urandom;
        do_start();
        load_image(4, 1'b1, 4, 60);
        post_load(4);
        random_run(1000, 2);

        // Reset mid-run, then a fresh image
        sel = 0; #1;
        set_prog(8);
        do_start();
        load_image(9, 1'b1, 256, 200);
        post_load(9);
        use_core = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        check_reset();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle_ready", s_ld_ready, 0);
        chk("post_rst_core", s_cpu_rst_n, 0);
        set_prog(9);
        do_start();
        load_image(9, 1'b1, 256, 200);
        post_load(9);
        core_run(100, 1'b0, 32'd1, 1'b0, 6);

        // Random images and writeback on the TIMEOUT=50 instance
        sel = 1; #1;
        for (int it = 0; it < 12; it++) begin
            int n;
            int fk;
            n = $urandom_range(1, 12);
            for (int w = 0; w < n; w++) img[w] = $urandom;
            case (it % 4)
                0:       fk = 49;
                1:       fk = 0;
                2:       fk = 50;
                default: fk = -1;
            endcase
            do_start();
            load_image(n, 1'b1, 256, 400);
            post_load(n);
            random_run(50, fk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
